// File: rtl/cv32e40x_bch_predictor_if.sv
// Shared control-transfer type and the ID/EX bus of the branch predictor.

package cv32e40x_bch_predictor_pkg;

    // Control-transfer type of the instruction currently in ID
    typedef enum logic [1:0] {
        CT_JAL  = 2'b01,
        CT_JALR = 2'b10,
        CT_BCH  = 2'b11
    } bch_jmp_mux_e;

endpackage

interface cv32e40x_bch_predictor_if
    import cv32e40x_bch_predictor_pkg::*;
#(
    parameter int unsigned MISP_CNT_W = 16
);

    // ID-stage target/prediction request
    bch_jmp_mux_e              bch_jmp_mux_sel_i;
    logic [31:0]               pc_id_i;
    logic [31:0]               imm_uj_type_i;
    logic [31:0]               imm_sb_type_i;
    logic [31:0]               imm_i_type_i;
    logic [31:0]               jalr_fw_i;

    // EX-stage branch resolution
    logic                      upd_valid_i;
    logic [31:0]               upd_pc_i;
    logic                      upd_taken_i;
    logic                      upd_predicted_i;

    // Results
    logic [31:0]               bch_target_o;
    logic [31:0]               jmp_target_o;
    logic                      bch_prediction_id_o;
    logic [MISP_CNT_W-1:0]     mispredict_cnt_o;

    modport master (
        output bch_jmp_mux_sel_i, pc_id_i, imm_uj_type_i, imm_sb_type_i,
               imm_i_type_i, jalr_fw_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_predicted_i,
        input  bch_target_o, jmp_target_o, bch_prediction_id_o, mispredict_cnt_o
    );

    modport slave (
        input  bch_jmp_mux_sel_i, pc_id_i, imm_uj_type_i, imm_sb_type_i,
               imm_i_type_i, jalr_fw_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_predicted_i,
        output bch_target_o, jmp_target_o, bch_prediction_id_o, mispredict_cnt_o
    );

endinterface

// File: rtl/cv32e40x_bch_predictor.sv
// ID-stage PC target unit with a BHT of saturating counters trained from EX.

module cv32e40x_bch_predictor
    import cv32e40x_bch_predictor_pkg::*;
#(
    parameter int unsigned BHT_DEPTH  = 16,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned DYN_PRED   = 1,
    parameter int unsigned MISP_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    cv32e40x_bch_predictor_if.slave  bus
);

    localparam int unsigned         IDX_W    = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_RST  = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [MISP_CNT_W-1:0] MISP_MAX = {MISP_CNT_W{1'b1}};

    logic [CNT_W-1:0]      bht_q [BHT_DEPTH];
    logic [CNT_W-1:0]      bht_d [BHT_DEPTH];
    logic [MISP_CNT_W-1:0] misp_cnt_q;
    logic [MISP_CNT_W-1:0] misp_cnt_d;

    logic [IDX_W-1:0]      lkp_idx;
    logic [IDX_W-1:0]      upd_idx;
    logic [CNT_W-1:0]      upd_cnt;
    logic [31:0]           pc_target;
    logic                  pred_dyn;
    logic                  pred_sta;
    logic                  unused_upd_pc;

    // Bit 0 is skipped so compressed instructions get distinct entries
    assign lkp_idx       = bus.pc_id_i[IDX_W:1];
    assign upd_idx       = bus.upd_pc_i[IDX_W:1];
    assign unused_upd_pc = ^{bus.upd_pc_i[31:IDX_W+1], bus.upd_pc_i[0]};

    // Target adder, JALR path doubles as the default
    always_comb begin
        pc_target = bus.jalr_fw_i + bus.imm_i_type_i;
        case (bus.bch_jmp_mux_sel_i)
            CT_JAL:  pc_target = bus.pc_id_i + bus.imm_uj_type_i;
            CT_BCH:  pc_target = bus.pc_id_i + bus.imm_sb_type_i;
            default: pc_target = bus.jalr_fw_i + bus.imm_i_type_i;
        endcase
    end

    assign bus.bch_target_o = pc_target;
    assign bus.jmp_target_o = pc_target;

    // Lookup reads the registered table only, so same-cycle updates are not bypassed
    assign pred_dyn = bht_q[lkp_idx][CNT_W-1];
    assign pred_sta = bus.imm_sb_type_i[31];

    assign bus.bch_prediction_id_o = (bus.bch_jmp_mux_sel_i == CT_BCH) &&
                                     ((DYN_PRED != 0) ? pred_dyn : pred_sta);

    assign bus.mispredict_cnt_o = misp_cnt_q;

    // Next state: one saturating counter step and the mispredict tally
    always_comb begin
        bht_d      = bht_q;
        misp_cnt_d = misp_cnt_q;
        upd_cnt    = bht_q[upd_idx];
        if (bus.upd_valid_i) begin
            if (bus.upd_taken_i) begin
                if (upd_cnt != CNT_MAX) begin
                    bht_d[upd_idx] = upd_cnt + CNT_W'(1);
                end
            end else begin
                if (upd_cnt != '0) begin
                    bht_d[upd_idx] = upd_cnt - CNT_W'(1);
                end
            end
            if ((bus.upd_taken_i != bus.upd_predicted_i) && (misp_cnt_q != MISP_MAX)) begin
                misp_cnt_d = misp_cnt_q + MISP_CNT_W'(1);
            end
        end
    end

    // State registers; reset overrides any concurrent update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CNT_RST;
            end
            misp_cnt_q <= '0;
        end else begin
            bht_q      <= bht_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

endmodule

// File: tb/tb_cv32e40x_bch_predictor.sv
// Directed bench: dynamic, static and narrow-counter predictor instances.

module tb_cv32e40x_bch_predictor;
    import cv32e40x_bch_predictor_pkg::*;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    cv32e40x_bch_predictor_if #(.MISP_CNT_W(16)) if0 ();
    cv32e40x_bch_predictor_if #(.MISP_CNT_W(16)) if1 ();
    cv32e40x_bch_predictor_if #(.MISP_CNT_W(2))  if2 ();

    cv32e40x_bch_predictor #(.BHT_DEPTH(16), .CNT_W(2), .DYN_PRED(1), .MISP_CNT_W(16)) u_dyn (
        .clk (clk), .rst (rst_a), .bus (if0.slave)
    );
    cv32e40x_bch_predictor #(.BHT_DEPTH(16), .CNT_W(2), .DYN_PRED(0), .MISP_CNT_W(16)) u_sta (
        .clk (clk), .rst (rst_a), .bus (if1.slave)
    );
    cv32e40x_bch_predictor #(.BHT_DEPTH(16), .CNT_W(2), .DYN_PRED(1), .MISP_CNT_W(2)) u_msp (
        .clk (clk), .rst (rst_b), .bus (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;

        if0.bch_jmp_mux_sel_i = CT_BCH; if0.pc_id_i = 32'h1004;
        if0.imm_uj_type_i = '0; if0.imm_sb_type_i = '0; if0.imm_i_type_i = '0; if0.jalr_fw_i = '0;
        if0.upd_valid_i = 1'b1; if0.upd_pc_i = 32'h1004; if0.upd_taken_i = 1'b1; if0.upd_predicted_i = 1'b0;

        if1.bch_jmp_mux_sel_i = CT_BCH; if1.pc_id_i = 32'h1000;
        if1.imm_uj_type_i = '0; if1.imm_sb_type_i = '0; if1.imm_i_type_i = '0; if1.jalr_fw_i = '0;
        if1.upd_valid_i = 1'b0; if1.upd_pc_i = '0; if1.upd_taken_i = 1'b0; if1.upd_predicted_i = 1'b0;

        if2.bch_jmp_mux_sel_i = CT_BCH; if2.pc_id_i = 32'h3000;
        if2.imm_uj_type_i = '0; if2.imm_sb_type_i = '0; if2.imm_i_type_i = '0; if2.jalr_fw_i = '0;
        if2.upd_valid_i = 1'b0; if2.upd_pc_i = 32'h3000; if2.upd_taken_i = 1'b0; if2.upd_predicted_i = 1'b0;

        // Reset with an update pending: update must be ignored
        tick();
        tick();
        chk("rst_pred", 32'(if0.bch_prediction_id_o), 32'd0);
        chk("rst_misp", 32'(if0.mispredict_cnt_o), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        if0.upd_valid_i = 1'b0;
        tick();
        chk("rst_pred_after", 32'(if0.bch_prediction_id_o), 32'd0);

        // Targets
        if0.bch_jmp_mux_sel_i = CT_JAL; if0.pc_id_i = 32'h0000_1000; if0.imm_uj_type_i = 32'h0000_0100;
        #1;
        chk("jal_bch_tgt", if0.bch_target_o, 32'h0000_1100);
        chk("jal_jmp_tgt", if0.jmp_target_o, 32'h0000_1100);
        chk("jal_pred", 32'(if0.bch_prediction_id_o), 32'd0);
        if0.bch_jmp_mux_sel_i = CT_JALR; if0.jalr_fw_i = 32'hFFFF_FFF0; if0.imm_i_type_i = 32'h20;
        #1;
        chk("jalr_wrap_tgt", if0.jmp_target_o, 32'h0000_0010);
        if0.bch_jmp_mux_sel_i = bch_jmp_mux_e'(2'b00);
        #1;
        chk("dflt_tgt", if0.bch_target_o, 32'h0000_0010);
        if0.bch_jmp_mux_sel_i = CT_BCH; if0.imm_sb_type_i = 32'h40;
        #1;
        chk("bch_tgt", if0.bch_target_o, 32'h0000_1040);

        // Training at 0x1004, first update also checks no-bypass on the same cycle
        if0.pc_id_i = 32'h1004;
        if0.upd_valid_i = 1'b1; if0.upd_pc_i = 32'h1004; if0.upd_taken_i = 1'b1; if0.upd_predicted_i = 1'b0;
        #1;
        chk("train_same_cycle", 32'(if0.bch_prediction_id_o), 32'd0);
        tick();
        chk("train_c2", 32'(if0.bch_prediction_id_o), 32'd1);
        chk("misp_1", 32'(if0.mispredict_cnt_o), 32'd1);
        if0.pc_id_i = 32'h1024;
        #1;
        chk("alias_1024", 32'(if0.bch_prediction_id_o), 32'd1);
        if0.pc_id_i = 32'h1004;
        if0.upd_predicted_i = 1'b1;
        tick();
        chk("train_c3", 32'(if0.bch_prediction_id_o), 32'd1);
        chk("misp_still_1", 32'(if0.mispredict_cnt_o), 32'd1);
        if0.upd_taken_i = 1'b0; if0.upd_predicted_i = 1'b1;
        tick();
        chk("nt_c2", 32'(if0.bch_prediction_id_o), 32'd1);
        chk("misp_2", 32'(if0.mispredict_cnt_o), 32'd2);
        tick();
        chk("nt_c1", 32'(if0.bch_prediction_id_o), 32'd0);
        chk("misp_3", 32'(if0.mispredict_cnt_o), 32'd3);
        if0.upd_predicted_i = 1'b0;
        tick();
        tick();
        if0.upd_taken_i = 1'b1; if0.upd_predicted_i = 1'b1;
        tick();
        chk("sat_low_then_taken", 32'(if0.bch_prediction_id_o), 32'd0);
        chk("misp_hold_3", 32'(if0.mispredict_cnt_o), 32'd3);

        // Saturation at the top, entry 0x1008
        if0.pc_id_i = 32'h1008; if0.upd_pc_i = 32'h1008;
        tick(); tick(); tick(); tick();
        chk("sat_high", 32'(if0.bch_prediction_id_o), 32'd1);
        if0.upd_taken_i = 1'b0; if0.upd_predicted_i = 1'b0;
        tick();
        chk("sat_high_dec1", 32'(if0.bch_prediction_id_o), 32'd1);
        tick();
        chk("sat_high_dec2", 32'(if0.bch_prediction_id_o), 32'd0);
        if0.upd_valid_i = 1'b0;

        // No bypass at 0x2000
        if0.pc_id_i = 32'h2000;
        if0.upd_valid_i = 1'b1; if0.upd_pc_i = 32'h2000; if0.upd_taken_i = 1'b1; if0.upd_predicted_i = 1'b1;
        #1;
        chk("nobyp_same", 32'(if0.bch_prediction_id_o), 32'd0);
        tick();
        if0.upd_valid_i = 1'b0;
        #1;
        chk("nobyp_next", 32'(if0.bch_prediction_id_o), 32'd1);
        chk("misp_3_again", 32'(if0.mispredict_cnt_o), 32'd3);

        // Reset wins over a concurrent mispredicting update
        rst_a = 1'b1;
        if0.upd_valid_i = 1'b1; if0.upd_taken_i = 1'b1; if0.upd_predicted_i = 1'b0;
        tick();
        chk("rstprio_misp", 32'(if0.mispredict_cnt_o), 32'd0);
        chk("rstprio_pred", 32'(if0.bch_prediction_id_o), 32'd0);
        rst_a = 1'b0;
        if0.upd_valid_i = 1'b0;
        if0.pc_id_i = 32'h1008;
        #1;
        chk("rstprio_1008", 32'(if0.bch_prediction_id_o), 32'd0);

        // Static BTFN instance
        if1.imm_sb_type_i = 32'hFFFF_FFF8;
        #1;
        chk("sta_back", 32'(if1.bch_prediction_id_o), 32'd1);
        chk("sta_back_tgt", if1.bch_target_o, 32'h0000_0FF8);
        if1.imm_sb_type_i = 32'h8;
        #1;
        chk("sta_fwd", 32'(if1.bch_prediction_id_o), 32'd0);
        if1.upd_valid_i = 1'b1; if1.upd_pc_i = 32'h1000; if1.upd_taken_i = 1'b1;
        tick(); tick(); tick();
        chk("sta_fwd_trained", 32'(if1.bch_prediction_id_o), 32'd0);
        if1.upd_taken_i = 1'b0; if1.imm_sb_type_i = 32'hFFFF_FFF8;
        tick(); tick(); tick();
        chk("sta_back_trained", 32'(if1.bch_prediction_id_o), 32'd1);
        if1.upd_valid_i = 1'b0;
        if1.bch_jmp_mux_sel_i = CT_JAL;
        #1;
        chk("sta_jal", 32'(if1.bch_prediction_id_o), 32'd0);

        // Narrow mispredict counter saturates, then reset clears it and the table
        if2.upd_valid_i = 1'b1; if2.upd_taken_i = 1'b1; if2.upd_predicted_i = 1'b0;
        tick();
        chk("msp_1", 32'(if2.mispredict_cnt_o), 32'd1);
        tick();
        chk("msp_2", 32'(if2.mispredict_cnt_o), 32'd2);
        tick();
        chk("msp_3", 32'(if2.mispredict_cnt_o), 32'd3);
        tick();
        chk("msp_sat", 32'(if2.mispredict_cnt_o), 32'd3);
        chk("msp_pred", 32'(if2.bch_prediction_id_o), 32'd1);
        rst_b = 1'b1;
        tick();
        chk("msp_rst_cnt", 32'(if2.mispredict_cnt_o), 32'd0);
        chk("msp_rst_pred", 32'(if2.bch_prediction_id_o), 32'd0);
        rst_b = 1'b0;
        if2.upd_valid_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40x_bch_predictor.md
Name: cv32e40x_bch_predictor

Overview:
- Successor to the combinational ID-stage PC target unit. Computes JAL, branch and JALR targets exactly as before.
- Adds a parametrised branch history table (BHT) of saturating counters to drive the ID-stage branch prediction. The table is trained by branch resolution from EX.
- Selectable static (BTFN) or dynamic prediction mode. Includes a saturating mispredict counter for performance observation.

Parameters:
- BHT_DEPTH, 16, number of BHT entries; power of two, ≥2.
- CNT_W, 2, width of each saturating counter; 1..4.
- DYN_PRED, 1, 1 = predict from BHT; 0 = static BTFN (backward taken, forward not taken). BHT still trains in both modes.
- MISP_CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- bch_jmp_mux_sel_i  in  bch_jmp_mux_e  control-transfer type in ID (CT_JAL/CT_BCH/CT_JALR).
- pc_id_i  in  32  PC of the ID instruction.
- imm_uj_type_i / imm_sb_type_i / imm_i_type_i  in  32 each  sign-extended immediates.
- jalr_fw_i  in  32  forwarded rs1 for JALR.
- upd_valid_i  in  1  branch resolved in EX this cycle.
- upd_pc_i  in  32  PC of the resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_predicted_i  in  1  prediction that was issued for this branch.
- bch_target_o  out  32  branch target.
- jmp_target_o  out  32  jump target.
- bch_prediction_id_o  out  1  predict-taken for the ID branch.
- mispredict_cnt_o  out  MISP_CNT_W  saturating mispredict count.

Behaviour:
- Single clock domain `clk`. Reset `rst` is synchronous and active-high; all state changes on the rising edge of `clk`.
- Target: pc_target = pc_id_i+imm_uj (CT_JAL), pc_id_i+imm_sb (CT_BCH), jalr_fw_i+imm_i (CT_JALR and default). Modulo-2^32 wrap, no overflow flag. Both target outputs equal pc_target.
- Targets are purely combinational and independent of reset.
- Index: idx = pc[IDX_W:1], where IDX_W = log2(BHT_DEPTH). Bit 0 is ignored, so compressed instructions are supported.
  - Lookup uses pc_id_i; update uses upd_pc_i.
- Prediction (combinational):
  - bch_prediction_id_o = 0 unless sel == CT_BCH.
  - DYN_PRED=1: output is the MSB of bht[idx(pc_id_i)].
  - DYN_PRED=0: output = 1 iff the signed imm_sb_type_i < 0, i.e. the target is below the PC with no wrap-around comparison.
- Reset: every counter is set to the weakly-not-taken value 2^(CNT_W-1)-1; for CNT_W=1 this is 0. mispredict_cnt_o = 0.
  - While rst is high, upd_valid_i is ignored.
  - Prediction outputs during reset reflect the reset table (combinational).
- Update: at a clock edge with upd_valid_i=1 and rst=0:
  - upd_taken_i=1: bht[idx(upd_pc_i)] increments, saturating at 2^CNT_W-1.
  - upd_taken_i=0: the counter decrements, saturating at 0.
  - Exactly one entry changes per cycle.
- Latency: an update is visible to lookups from the next cycle on. A same-cycle lookup of the entry being updated returns the pre-update value; there is no bypass.
- Mispredict counter: increments by 1 on an update edge with upd_taken_i != upd_predicted_i. Saturates at all-ones and never wraps.
- Aliasing: PCs sharing idx share an entry. This is intended; there are no tags.
- Reset asserted in the same cycle as an update: reset wins and the update is dropped.

Test Plan:
- Targets: pc_id=0x0000_1000, imm_uj=0x0000_0100, sel=CT_JAL -> bch/jmp_target=0x0000_1100. Set sel=CT_JALR, jalr_fw=0xFFFF_FFF0, imm_i=0x20 -> target=0x0000_0010 (wrap).
- Reset state: after rst, CT_BCH at any PC -> prediction=0 (counter=1). Same cycle with sel=CT_JAL -> prediction=0. mispredict_cnt_o=0.
- Training: two taken updates at upd_pc=0x1004 -> counter 1→2→3. A CT_BCH lookup at 0x1004 on the cycle after the first update -> prediction=1. Lookup at 0x1024 (same idx, depth 16) -> 1 (alias).
  - Three not-taken updates -> counter 3→2→1→0, saturating at 0. A fourth not-taken update keeps 0.
- No bypass: at 0x2000 with counter=1, drive upd_valid (taken) and a same-cycle ID lookup -> 0 this cycle, 1 next cycle.
- Static mode (DYN_PRED=0): imm_sb=0xFFFF_FFF8 -> prediction=1; imm_sb=0x8 -> 0. Any amount of BHT training leaves these results unchanged.
- Mispredict counter and reset priority:
  - With MISP_CNT_W=2, four mispredicting updates -> count 1,2,3,3.
  - Then rst held with upd_valid=1 -> count=0 and the BHT is back at reset values.
